// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone classic slave exposing ID, CTRL, STATUS and a
// host-to-device TX FIFO plus a device-to-host RX FIFO.
module wb_fifo_slave #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_CYC,
    input  logic        wb_STB,
    input  logic        wb_WE,
    input  logic [13:0] wb_ADR,
    input  logic [3:0]  wb_SEL,
    input  logic [31:0] wb_DAT_MOSI,
    output logic [31:0] wb_DAT_MISO,
    output logic        wb_ACK,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] ID_WORD = 32'h5542_4601;

    typedef logic [DEPTH_LOG2:0]   lvl_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    // Control / sticky state
    logic enable, rx_irq_en, tx_irq_en;
    logic tx_ovf, rx_unf;

    // FIFO storage and bookkeeping; level is kept apart from the pointers
    // so that full and empty are distinguishable when the pointers match.
    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];
    ptr_t        tx_rd, tx_wr, rx_rd, rx_wr;
    lvl_t        tx_level, rx_level;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic req, hit, wr_ok, rd_ok;
    logic ctrl_wr, stat_wr, txd_wr, rxd_rd;
    logic tx_flush, rx_flush;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [2:0]  reg_sel;
    logic [31:0] status_word, rd_data;

    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == lvl_t'(DEPTH));
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == lvl_t'(DEPTH));

    // A request is only taken while ACK is low, so at most every other cycle
    assign req     = wb_CYC & wb_STB & ~wb_ACK;
    assign hit     = (wb_ADR[13:3] == 11'd0);
    assign reg_sel = wb_ADR[2:0];
    assign wr_ok   = req & wb_WE & hit & (wb_SEL == 4'hF);
    assign rd_ok   = req & ~wb_WE & hit;

    assign ctrl_wr = wr_ok & (reg_sel == 3'd1);
    assign stat_wr = wr_ok & (reg_sel == 3'd2);
    assign txd_wr  = wr_ok & (reg_sel == 3'd3);
    assign rxd_rd  = rd_ok & (reg_sel == 3'd4);

    assign tx_flush = ctrl_wr & wb_DAT_MOSI[8];
    assign rx_flush = ctrl_wr & wb_DAT_MOSI[9];

    // Device-side handshakes and irq come from registered state only
    assign tx_valid = enable & ~tx_empty;
    assign tx_data  = tx_mem[tx_rd];
    assign rx_ready = enable & ~rx_full;
    assign irq      = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);

    // Full-ness is judged on pre-edge state, so a push into a full FIFO is
    // dropped even if the consumer pops on the same edge.
    assign tx_push = txd_wr & ~tx_full;
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = rxd_rd & ~rx_empty;

    // STATUS image built from pre-edge state
    always_comb begin
        status_word = '0;
        status_word[DEPTH_LOG2:0]     = tx_level;
        status_word[4]                = tx_full;
        status_word[5]                = tx_empty;
        status_word[8+DEPTH_LOG2:8]   = rx_level;
        status_word[12]               = rx_full;
        status_word[13]               = rx_empty;
        status_word[16]               = tx_ovf;
        status_word[17]               = rx_unf;
    end

    // Read mux; unmapped, out-of-window and write accesses return 0
    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            case (reg_sel)
                3'd0:    rd_data = ID_WORD;
                3'd1:    rd_data = {29'd0, tx_irq_en, rx_irq_en, enable};
                3'd2:    rd_data = status_word;
                3'd4:    rd_data = rx_empty ? 32'd0 : rx_mem[rx_rd];
                default: rd_data = '0;
            endcase
        end
    end

    // Bus response, CTRL register and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ACK      <= 1'b0;
            wb_DAT_MISO <= '0;
            enable      <= 1'b0;
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            tx_ovf      <= 1'b0;
            rx_unf      <= 1'b0;
        end else begin
            wb_ACK <= req;
            if (req)
                wb_DAT_MISO <= rd_data;
            if (ctrl_wr) begin
                enable    <= wb_DAT_MOSI[0];
                rx_irq_en <= wb_DAT_MOSI[1];
                tx_irq_en <= wb_DAT_MOSI[2];
            end
            if (txd_wr & tx_full)
                tx_ovf <= 1'b1;
            else if (stat_wr & wb_DAT_MOSI[16])
                tx_ovf <= 1'b0;
            if (rxd_rd & rx_empty)
                rx_unf <= 1'b1;
            else if (stat_wr & wb_DAT_MOSI[17])
                rx_unf <= 1'b0;
        end
    end

    // TX FIFO: host pushes, device pops; flush overrides both
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_rd    <= '0;
            tx_wr    <= '0;
            tx_level <= '0;
            for (int i = 0; i < DEPTH; i++)
                tx_mem[i] <= '0;
        end else if (tx_flush) begin
            tx_rd    <= '0;
            tx_wr    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= wb_DAT_MOSI;
                tx_wr         <= tx_wr + ptr_t'(1);
            end
            if (tx_pop)
                tx_rd <= tx_rd + ptr_t'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + lvl_t'(1);
                2'b01:   tx_level <= tx_level - lvl_t'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    // RX FIFO: device pushes, host RXDATA reads pop; flush overrides both
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_level <= '0;
            for (int i = 0; i < DEPTH; i++)
                rx_mem[i] <= '0;
        end else if (rx_flush) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_data;
                rx_wr         <= rx_wr + ptr_t'(1);
            end
            if (rx_pop)
                rx_rd <= rx_rd + ptr_t'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + lvl_t'(1);
                2'b01:   rx_level <= rx_level - lvl_t'(1);
                default: rx_level <= rx_level;
            endcase
        end
    end

endmodule

// File: doc/wb_fifo_slave.md
# wb_fifo_slave

Wishbone classic slave sitting directly downstream of the pin-level Wishbone master, on its 14-bit word-address / 32-bit data bus. It exposes an ID word, a control register, a status register and two 32-bit FIFOs to the host. The TX FIFO is pushed by host writes and drained by the device-side consumer. The RX FIFO is filled by the device-side producer and popped by host reads. It is the host's data path into and out of the USB device core.

## Interface
Parameters:
- DEPTH_LOG2, default 2: each FIFO holds 2^DEPTH_LOG2 words, 4 by default. Level fields are DEPTH_LOG2+1 bits wide.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_CYC  in  1  bus cycle.
- wb_STB  in  1  strobe.
- wb_WE  in  1  1 = write.
- wb_ADR  in  14  word address; byte bits [1:0] are implicit zero.
- wb_SEL  in  4  byte enables.
- wb_DAT_MOSI  in  32  write data.
- wb_DAT_MISO  out  32  read data.
- wb_ACK  out  1  single-cycle acknowledge.
- tx_data  out  32  TX FIFO head word.
- tx_valid  out  1  TX head valid.
- tx_ready  in  1  consumer takes head.
- rx_data  in  32  producer word.
- rx_valid  in  1  producer word valid.
- rx_ready  out  1  RX FIFO can accept.
- irq  out  1  level interrupt.

## Operation
- Access request: wb_CYC & wb_STB & !wb_ACK. On the edge that samples a request, wb_ACK is set for exactly one cycle, the side effect is committed, and wb_DAT_MISO is registered.
- The master must drop STB after sampling ACK. The slave therefore acks at most every other cycle.
- Decode uses wb_ADR[2:0]. If wb_ADR[13:3] != 0, the access is acked with no effect and reads return 0.
- Register map by word address:
  - 0 ID: RO, 32'h5542_4601.
  - 1 CTRL: RW.
    - [0] enable.
    - [1] rx_irq_en.
    - [2] tx_irq_en.
    - [8] tx_flush, write-1, self-clearing, reads 0.
    - [9] rx_flush, write-1, self-clearing, reads 0.
  - 2 STATUS: RO except W1C bits.
    - [DEPTH_LOG2:0] tx_level.
    - [4] tx_full, [5] tx_empty.
    - [8+DEPTH_LOG2:8] rx_level.
    - [12] rx_full, [13] rx_empty.
    - [16] tx_ovf, sticky, W1C.
    - [17] rx_unf, sticky, W1C.
  - 3 TXDATA: WO. A write pushes wb_DAT_MOSI; a read returns 0.
  - 4 RXDATA: RO. A read pops the RX head and returns it; a write has no effect.
  - 5–7: read 0, write ignored.
- Any write with wb_SEL != 4'hF is acked with no effect.
- Write to TXDATA when tx_full (pre-edge state): word dropped and tx_ovf set. This holds even if a consumer pop occurs on the same edge.
- Read of RXDATA when rx_empty: returns 0 and sets rx_unf.
- tx_valid = enable & !tx_empty. tx_data = mem[tx_rd]. A pop occurs when tx_valid & tx_ready.
- rx_ready = enable & !rx_full. A push occurs when rx_valid & rx_ready.
- Simultaneous push and pop on one FIFO (not full/empty): both take effect and the level is unchanged.
- A flush clears that FIFO's pointers and level on the same edge. Flush wins over any simultaneous push or pop on that FIFO. Sticky bits are unaffected.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Level is tracked separately to distinguish full from empty.
- irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty). It is derived from registered state only.
- enable=0 blocks both device-side handshakes. The host side remains fully functional.

## Timing
- Reset values:
  - wb_ACK=0, wb_DAT_MISO=0.
  - CTRL=0, both FIFOs empty, sticky bits 0, FIFO storage cleared.
  - tx_data=0, tx_valid=0, rx_ready=0, irq=0.
- Access latency: request sampled at edge N → ACK high in cycle N+1 with wb_DAT_MISO valid. wb_DAT_MISO holds until the next ACK.
- Side effects (push, pop, CTRL update, W1C) are visible in STATUS and the device-side outputs from cycle N+1.
- STATUS read on the same edge as a device-side push or pop returns the pre-edge value.
- Reset asserted mid-access: ACK is low the next cycle and no side effect occurs on that edge.

## Test plan
- Reset, then read addresses 0, 1, 2 → 0x55424601, 0x0, STATUS = 0x0000_2020; ACK is one cycle, one cycle after STB.
- CTRL=1; write TXDATA 0x11111111..0x44444444 with tx_ready=0 → tx_level=4, tx_full=1. A 5th write → tx_ovf=1. Then tx_ready=1 drains 0x11111111..0x44444444 in order, one per cycle.
- CTRL=1; drive rx_data 0xA0..0xA4 with rx_valid held → rx_ready drops after 4 words. RXDATA reads return 0xA0, 0xA1, 0xA2, 0xA3; a 5th read returns 0 and sets rx_unf. Writing STATUS 0x00030000 clears both sticky bits.
- TX level 2 with tx_ready=1 and a TXDATA write on the same edge → level stays 2 and order is preserved.
- CTRL=0x6 with both FIFOs empty → irq=1 (tx empty). Write CTRL=0x106 with TX holding 3 words → level 0, irq=1. Write with wb_SEL=4'h3 → no effect, still acked.
- Assert reset during an ACK-pending cycle with an RX word queued → no ACK follows, RX FIFO empty, all outputs at reset values.
